cbfp_win_ctrl: RTL and testbench
================================

// Module: cbfp_win_ctrl
// PURPOSE
//   Parametrised enable-window generator for the CBFP stages. Each trigger pulse (e.g. mag_en from the
//   magnitude stage) opens a window of WIN_LEN cycles, driving the min-search / shift enables downstream.
//   Extends the fixed 32-cycle single-shot controller with a programmable length, queued retriggers for
//   back-to-back windows, stall, window/block indices and frame tracking.
// PARAMETERS
//   WIN_LEN    32  window length in cycles (>=2)
//   NUM_BLK    16  windows per frame; blk_idx wraps after NUM_BLK windows (>=1)
//   PEND_MAX   2   max queued triggers accepted while a window is running (>=1)
// PORTS
//   clk        in   1                     clock, all logic on rising edge
//   rst        in   1                     synchronous, active-high reset
//   trig       in   1                     window request pulse (one request per high cycle)
//   stall      in   1                     freeze window progress while high
//   clr        in   1                     synchronous soft clear (same effect as rst)
//   win_en     out  1                     window active and not stalled
//   win_first  out  1                     first active cycle of a window
//   win_last   out  1                     last active cycle of a window
//   win_idx    out  $clog2(WIN_LEN)       cycle index in window, 0..WIN_LEN-1
//   blk_idx    out  $clog2(NUM_BLK)|1     index of current/next window in frame (min width 1)
//   frame_done out  1                     pulse: last cycle of window NUM_BLK-1
//   pend_cnt   out  $clog2(PEND_MAX+1)    queued triggers
//   ovf        out  1                     sticky: trigger dropped because queue full
// BEHAVIOUR
//   - Reset (rst or clr, clr has equal priority): state=IDLE; all outputs 0, win_idx=0, blk_idx=0, pend_cnt=0,
//     ovf=0. Reset mid-window aborts immediately; no frame_done, queued triggers discarded.
//   - All outputs are registered. Latency: trig high in cycle N while IDLE -> win_en=1, win_first=1,
//     win_idx=0 in cycle N+1.
//   - FSM states: IDLE, RUN, HOLD.
//     IDLE: trig -> RUN, win_idx<=0. No trig -> stay.
//     RUN: win_en=1; win_idx increments each cycle. win_last=1 when win_idx==WIN_LEN-1.
//       stall high -> HOLD next cycle (win_en=0, win_idx held, first/last 0).
//       On the win_last cycle: blk_idx<=blk_idx+1 (wrap to 0 after NUM_BLK-1); frame_done=1 in same
//       cycle iff blk_idx==NUM_BLK-1. Next: pend_cnt>0 (or trig in this cycle) -> RUN again with
//       win_idx=0, win_first=1 (zero-gap back-to-back), consuming one request; else IDLE.
//     HOLD: win_en=0; stall low -> RUN, resuming at held win_idx+1? No: resumes at held win_idx
//       (no index is skipped or repeated in win_en-high cycles); win_first/win_last reassert only
//       if the resumed index is 0 / WIN_LEN-1.
//   - Each window has exactly WIN_LEN cycles with win_en=1, regardless of stalls.
//   - stall in IDLE has no effect; trig during IDLE+stall starts in HOLD at win_idx=0.
//   - Triggers while RUN/HOLD: pend_cnt++ (saturating at PEND_MAX). Trig with pend_cnt==PEND_MAX -> dropped,
//     ovf<=1 (sticky until rst/clr).
//   - Trig on the win_last cycle: net pend_cnt unchanged (one added, one consumed) when queue non-empty;
//     when queue empty it directly starts the next window, pend_cnt stays 0. Never counted as overflow
//     if it is consumed in the same cycle.
//   - win_first and win_last are both 1 only if WIN_LEN==1 (disallowed; WIN_LEN>=2).
//   - frame_done is a single-cycle pulse, coincident with win_last; never asserted in HOLD.
// TESTING
//   1 WIN_LEN=32: single trig pulse at cycle 10 -> win_en high cycles 11..42, win_first@11, win_last@42,
//     win_idx 0..31, blk_idx 0->1 after cycle 42, then IDLE.
//   2 Trig at cycle 10 and again at 20 -> pend_cnt=1 from 21; windows at 11..42 and 43..74 with no gap;
//     pend_cnt back to 0 at 43.
//   3 PEND_MAX=2: 4 trigs during one window -> pend_cnt saturates at 2, ovf=1 and stays 1; exactly 3 windows total.
//   4 stall high for 5 cycles starting at win_idx=7 -> win_en low 5 cycles, win_idx resumes at 7,
//     window end delayed by 5 cycles; exactly 32 win_en cycles counted.
//   5 NUM_BLK=4, 4 back-to-back windows -> frame_done pulses once, on win_last of window 3; blk_idx wraps to 0.
//   6 rst (then separately clr) asserted at win_idx=15 with pend_cnt=1 -> next cycle all outputs 0, no further windows.

Source files
------------

// File: rtl/cbfp_win_ctrl.sv
// cbfp_win_ctrl
//   Enable-window generator for the CBFP stages. Each trigger opens a window
//   of WIN_LEN enabled cycles that drives the downstream min-search / shift
//   logic. Triggers that arrive while a window is running are queued (up to
//   PEND_MAX) so windows can run back-to-back with no gap. A stall freezes
//   window progress without losing or repeating any index. Windows are
//   counted per frame of NUM_BLK windows.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   trig       in   window request, one request per high cycle
//   stall      in   freeze window progress while high
//   clr        in   synchronous soft clear, same effect as rst
//   win_en     out  window active and not stalled
//   win_first  out  first active cycle of a window
//   win_last   out  last active cycle of a window
//   win_idx    out  cycle index within the window
//   blk_idx    out  index of the current/next window in the frame
//   frame_done out  pulse on the last cycle of window NUM_BLK-1
//   pend_cnt   out  number of queued triggers
//   ovf        out  sticky: a trigger was dropped because the queue was full
//
// All outputs are registered.
module cbfp_win_ctrl #(
    parameter int WIN_LEN  = 32,
    parameter int NUM_BLK  = 16,
    parameter int PEND_MAX = 2,
    localparam int IDX_W   = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1,
    localparam int BLK_W   = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1,
    localparam int PEND_W  = $clog2(PEND_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic              stall,
    input  logic              clr,
    output logic              win_en,
    output logic              win_first,
    output logic              win_last,
    output logic [IDX_W-1:0]  win_idx,
    output logic [BLK_W-1:0]  blk_idx,
    output logic              frame_done,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIN_LEN - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(NUM_BLK - 1);
    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx_nxt;
    logic [BLK_W-1:0]  blk_nxt;
    logic [PEND_W-1:0] pend_nxt;
    logic              ovf_nxt;
    logic              take_req;
    logic              run_nxt;

    always_comb begin
        state_nxt = state;
        idx_nxt   = win_idx;
        blk_nxt   = blk_idx;
        pend_nxt  = pend_cnt;
        ovf_nxt   = ovf;
        take_req  = 1'b0;

        case (state)
            IDLE: begin
                // A stall at trigger time parks the new window at index 0.
                if (trig) begin
                    state_nxt = stall ? HOLD : RUN;
                    idx_nxt   = '0;
                end
            end

            RUN: begin
                if (win_idx == IDX_LAST) begin
                    blk_nxt = (blk_idx == BLK_LAST) ? '0 : blk_idx + BLK_W'(1);
                    idx_nxt = '0;
                    // A trigger on the last cycle is consumed directly: with an
                    // empty queue it starts the next window, otherwise it
                    // replaces the queued request being consumed.
                    if ((pend_cnt != '0) || trig) begin
                        state_nxt = stall ? HOLD : RUN;
                        if (!trig) begin
                            pend_nxt = pend_cnt - PEND_W'(1);
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    // The index shown in HOLD is the next one still owed, so
                    // resuming at it neither skips nor repeats an index.
                    idx_nxt   = win_idx + IDX_W'(1);
                    state_nxt = stall ? HOLD : RUN;
                    take_req  = trig;
                end
            end

            HOLD: begin
                state_nxt = stall ? HOLD : RUN;
                take_req  = trig;
            end

            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase

        if (take_req) begin
            if (pend_cnt == PEND_FULL) begin
                ovf_nxt = 1'b1;
            end else begin
                pend_nxt = pend_cnt + PEND_W'(1);
            end
        end
    end

    assign run_nxt = (state_nxt == RUN);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state      <= IDLE;
            win_en     <= 1'b0;
            win_first  <= 1'b0;
            win_last   <= 1'b0;
            win_idx    <= '0;
            blk_idx    <= '0;
            frame_done <= 1'b0;
            pend_cnt   <= '0;
            ovf        <= 1'b0;
        end else begin
            state      <= state_nxt;
            win_en     <= run_nxt;
            win_first  <= run_nxt && (idx_nxt == '0);
            win_last   <= run_nxt && (idx_nxt == IDX_LAST);
            win_idx    <= idx_nxt;
            blk_idx    <= blk_nxt;
            frame_done <= run_nxt && (idx_nxt == IDX_LAST) && (blk_nxt == BLK_LAST);
            pend_cnt   <= pend_nxt;
            ovf        <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_cbfp_win_ctrl.sv
module tb_cbfp_win_ctrl;

    localparam int WIN_LEN  = 32;
    localparam int NUM_BLK  = 4;
    localparam int PEND_MAX = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trig = 1'b0;
    logic       stall = 1'b0;
    logic       clr = 1'b0;
    logic       win_en, win_first, win_last, frame_done, ovf;
    logic [4:0] win_idx;
    logic [1:0] blk_idx;
    logic [1:0] pend_cnt;

    int n_checks = 0;
    int n_err    = 0;

    cbfp_win_ctrl #(
        .WIN_LEN (WIN_LEN),
        .NUM_BLK (NUM_BLK),
        .PEND_MAX(PEND_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .trig      (trig),
        .stall     (stall),
        .clr       (clr),
        .win_en    (win_en),
        .win_first (win_first),
        .win_last  (win_last),
        .win_idx   (win_idx),
        .blk_idx   (blk_idx),
        .frame_done(frame_done),
        .pend_cnt  (pend_cnt),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference model: a window is a count of enabled cycles delivered so far,
    // plus a paused flag, a request count and a completed-window count.
    bit m_busy, m_paused, m_ovf;
    int m_done, m_q, m_wins;

    function automatic int pack(bit en, bit first, bit last, int idx, int blk,
                                bit fd, int pend, bit ov);
        return {18'd0, en, first, last, idx[4:0], blk[1:0], fd, pend[1:0], ov};
    endfunction

    function automatic int model_pack();
        bit en;
        en = m_busy && !m_paused;
        return pack(en, en && (m_done == 0), en && (m_done == WIN_LEN - 1), m_done,
                    m_wins, en && (m_done == WIN_LEN - 1) && (m_wins == NUM_BLK - 1),
                    m_q, m_ovf);
    endfunction

    function automatic int dut_pack();
        return pack(win_en, win_first, win_last, int'(win_idx), int'(blk_idx),
                    frame_done, int'(pend_cnt), ovf);
    endfunction

    task automatic model_enqueue(input bit t);
        if (t) begin
            if (m_q < PEND_MAX) m_q++;
            else m_ovf = 1'b1;
        end
    endtask

    task automatic model_step(input bit t, input bit s, input bit r);
        if (r) begin
            m_busy = 0; m_paused = 0; m_ovf = 0; m_done = 0; m_q = 0; m_wins = 0;
        end else if (!m_busy) begin
            if (t) begin
                m_busy = 1; m_done = 0; m_paused = s;
            end
        end else if (!m_paused) begin
            if (m_done == WIN_LEN - 1) begin
                m_wins = (m_wins + 1) % NUM_BLK;
                if (m_q > 0 || t) begin
                    if (!t) m_q--;
                    m_done = 0; m_paused = s;
                end else begin
                    m_busy = 0; m_done = 0; m_paused = 0;
                end
            end else begin
                m_done++;
                m_paused = s;
                model_enqueue(t);
            end
        end else begin
            m_paused = s;
            model_enqueue(t);
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge.
    task automatic step(input bit t, input bit s, input bit r, input bit c);
        trig = t; stall = s; rst = r; clr = c;
        model_step(t, s, r | c);
        @(posedge clk);
        #1;
        check("model", dut_pack(), model_pack());
    endtask

    typedef struct {
        int rep;
        bit trig, stall, rst, clr;
        bit en, first, last;
        int idx, blk;
        bit fd;
        int pend;
        bit ov;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int rep, input bit t, input bit s, input bit r, input bit c,
                       input bit en, input bit f, input bit l, input int idx, input int blk,
                       input bit fd, input int pend, input bit ov);
        vec_t v;
        v.rep = rep; v.trig = t; v.stall = s; v.rst = r; v.clr = c;
        v.en = en; v.first = f; v.last = l; v.idx = idx; v.blk = blk;
        v.fd = fd; v.pend = pend; v.ov = ov;
        tbl.push_back(v);
    endtask

    initial begin
        int en_cnt, first_cnt, fd_cnt, first_en, last_en, low_cnt, exp_idx, seq_bad;
        bit t, s, r, c;

        //   rep trg stl rst clr  en fst lst idx blk fd pend ovf
        add(2,  0, 0, 1, 0,   0, 0, 0,  0, 0, 0, 0, 0);  // reset
        add(3,  0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0, 0);
        add(1,  1, 0, 0, 0,   1, 1, 0,  0, 0, 0, 0, 0);  // single window
        add(7,  0, 0, 0, 0,   1, 0, 0,  7, 0, 0, 0, 0);
        add(24, 0, 0, 0, 0,   1, 0, 1, 31, 0, 0, 0, 0);
        add(1,  0, 0, 0, 0,   0, 0, 0,  0, 1, 0, 0, 0);
        add(1,  1, 0, 0, 0,   1, 1, 0,  0, 1, 0, 0, 0);  // queued retrigger
        add(8,  0, 0, 0, 0,   1, 0, 0,  8, 1, 0, 0, 0);
        add(1,  1, 0, 0, 0,   1, 0, 0,  9, 1, 0, 1, 0);
        add(22, 0, 0, 0, 0,   1, 0, 1, 31, 1, 0, 1, 0);
        add(1,  0, 0, 0, 0,   1, 1, 0,  0, 2, 0, 0, 0);
        add(31, 0, 0, 0, 0,   1, 0, 1, 31, 2, 0, 0, 0);
        add(1,  0, 0, 0, 0,   0, 0, 0,  0, 3, 0, 0, 0);
        add(1,  1, 0, 0, 0,   1, 1, 0,  0, 3, 0, 0, 0);  // frame end
        add(31, 0, 0, 0, 0,   1, 0, 1, 31, 3, 1, 0, 0);
        add(1,  0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0, 0);
        add(1,  1, 0, 0, 0,   1, 1, 0,  0, 0, 0, 0, 0);  // trig on last cycle
        add(31, 0, 0, 0, 0,   1, 0, 1, 31, 0, 0, 0, 0);
        add(1,  1, 0, 0, 0,   1, 1, 0,  0, 1, 0, 0, 0);
        add(31, 0, 0, 0, 0,   1, 0, 1, 31, 1, 0, 0, 0);
        add(1,  0, 0, 0, 0,   0, 0, 0,  0, 2, 0, 0, 0);
        add(1,  1, 0, 0, 0,   1, 1, 0,  0, 2, 0, 0, 0);  // overflow
        add(2,  1, 0, 0, 0,   1, 0, 0,  2, 2, 0, 2, 0);
        add(2,  1, 0, 0, 0,   1, 0, 0,  4, 2, 0, 2, 1);
        add(27, 0, 0, 0, 0,   1, 0, 1, 31, 2, 0, 2, 1);
        add(1,  0, 0, 0, 0,   1, 1, 0,  0, 3, 0, 1, 1);
        add(31, 0, 0, 0, 0,   1, 0, 1, 31, 3, 1, 1, 1);
        add(1,  0, 0, 0, 0,   1, 1, 0,  0, 0, 0, 0, 1);
        add(32, 0, 0, 0, 0,   0, 0, 0,  0, 1, 0, 0, 1);
        add(1,  1, 0, 0, 0,   1, 1, 0,  0, 1, 0, 0, 1);  // stall
        add(6,  0, 0, 0, 0,   1, 0, 0,  6, 1, 0, 0, 1);
        add(1,  0, 1, 0, 0,   0, 0, 0,  7, 1, 0, 0, 1);
        add(4,  0, 1, 0, 0,   0, 0, 0,  7, 1, 0, 0, 1);
        add(1,  0, 0, 0, 0,   1, 0, 0,  7, 1, 0, 0, 1);
        add(24, 0, 0, 0, 0,   1, 0, 1, 31, 1, 0, 0, 1);
        add(1,  0, 0, 0, 0,   0, 0, 0,  0, 2, 0, 0, 1);
        add(1,  1, 1, 0, 0,   0, 0, 0,  0, 2, 0, 0, 1);  // trig while stalled
        add(2,  0, 1, 0, 0,   0, 0, 0,  0, 2, 0, 0, 1);
        add(1,  0, 0, 0, 0,   1, 1, 0,  0, 2, 0, 0, 1);
        add(31, 0, 0, 0, 0,   1, 0, 1, 31, 2, 0, 0, 1);
        add(1,  0, 0, 0, 0,   0, 0, 0,  0, 3, 0, 0, 1);
        add(1,  1, 0, 0, 0,   1, 1, 0,  0, 3, 0, 0, 1);  // rst mid-window
        add(5,  0, 0, 0, 0,   1, 0, 0,  5, 3, 0, 0, 1);
        add(1,  1, 0, 0, 0,   1, 0, 0,  6, 3, 0, 1, 1);
        add(9,  0, 0, 0, 0,   1, 0, 0, 15, 3, 0, 1, 1);
        add(1,  0, 0, 1, 0,   0, 0, 0,  0, 0, 0, 0, 0);
        add(40, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0, 0);
        add(1,  1, 0, 0, 0,   1, 1, 0,  0, 0, 0, 0, 0);  // clr mid-window
        add(5,  0, 0, 0, 0,   1, 0, 0,  5, 0, 0, 0, 0);
        add(1,  1, 0, 0, 0,   1, 0, 0,  6, 0, 0, 1, 0);
        add(9,  0, 0, 0, 0,   1, 0, 0, 15, 0, 0, 1, 0);
        add(1,  0, 0, 0, 1,   0, 0, 0,  0, 0, 0, 0, 0);
        add(40, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0, 0);

        m_busy = 0; m_paused = 0; m_ovf = 0; m_done = 0; m_q = 0; m_wins = 0;

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].rep; k++)
                step(tbl[i].trig, tbl[i].stall, tbl[i].rst, tbl[i].clr);
            check($sformatf("vec%0d", i), dut_pack(),
                  pack(tbl[i].en, tbl[i].first, tbl[i].last, tbl[i].idx, tbl[i].blk,
                       tbl[i].fd, tbl[i].pend, tbl[i].ov));
        end

        // Four back-to-back windows in one frame.
        step(0, 0, 1, 0);
        en_cnt = 0; first_cnt = 0; fd_cnt = 0; first_en = -1; last_en = -1;
        for (int k = 0; k < 160; k++) begin
            step((k < 3) || (k == 40), 0, 0, 0);
            if (win_en) begin
                en_cnt++;
                if (first_en < 0) first_en = k;
                last_en = k;
            end
            if (win_first) first_cnt++;
            if (frame_done) fd_cnt++;
        end
        check("b2b_en_cycles", en_cnt, 4 * WIN_LEN);
        check("b2b_no_gap", last_en - first_en + 1, 4 * WIN_LEN);
        check("b2b_windows", first_cnt, 4);
        check("b2b_frame_done", fd_cnt, 1);
        check("b2b_blk_wrap", int'(blk_idx), 0);

        // Stall of five cycles inside a window.
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        en_cnt = 0; low_cnt = 0; exp_idx = 0; seq_bad = 0;
        if (win_en) begin
            en_cnt++;
            if (int'(win_idx) != exp_idx) seq_bad++;
            exp_idx++;
        end
        for (int k = 0; k < 70; k++) begin
            step(0, (k >= 6) && (k < 11), 0, 0);
            if (win_en) begin
                en_cnt++;
                if (int'(win_idx) != exp_idx) seq_bad++;
                exp_idx++;
            end else if (en_cnt > 0 && en_cnt < WIN_LEN) begin
                low_cnt++;
            end
        end
        check("stall_en_cycles", en_cnt, WIN_LEN);
        check("stall_idx_seq", seq_bad, 0);
        check("stall_low_cycles", low_cnt, 5);

        // Randomized traffic against the model.
        step(0, 0, 1, 0);
        for (int k = 0; k < 4000; k++) begin
            if (((k / 500) % 2) == 1) t = ($urandom_range(0, 2) == 0);
            else t = ($urandom_range(0, 19) == 0);
            s = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 799) == 0);
            c = ($urandom_range(0, 499) == 0);
            step(t, s, r, c);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
